// File: rtl/as512_bus_pkg.sv
// Shared constants, region type and address decode for the as512 memory-side bus bridge.
package as512_bus_pkg;

   localparam logic [15:0] CTRL_BASE_HI  = 16'hFFFF;
   localparam logic [15:0] ADDR_HI_RESET = 16'hFFFF;
   localparam logic [15:0] LOCK_KEY      = 16'hA55A;
   localparam logic [15:0] UNMAPPED_DATA = 16'hFFFF;

   // Control-register window indices (addr_lo[2:0]).
   localparam logic [2:0] CTRL_RD_LO    = 3'd0;
   localparam logic [2:0] CTRL_RD_HI    = 3'd1;
   localparam logic [2:0] CTRL_WR_LO    = 3'd2;
   localparam logic [2:0] CTRL_WR_HI    = 3'd3;
   localparam logic [2:0] CTRL_WP_LIMIT = 3'd4;
   localparam logic [2:0] CTRL_LOCK     = 3'd5;
   localparam logic [2:0] CTRL_FA_LO    = 3'd6;
   localparam logic [2:0] CTRL_FA_HI    = 3'd7;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_CTRL,
      REGION_UNMAPPED
   } region_e;

   // Classify a full {hi, lo} word address into RAM, control window or unmapped.
   function automatic region_e decode(input logic [15:0] hi, input logic [15:0] lo,
                                      input int ram_aw);
      if (hi == 16'h0000 && (lo >> ram_aw) == 16'h0000) return REGION_RAM;
      if (hi == CTRL_BASE_HI && lo[15:3] == 13'h0000) return REGION_CTRL;
      return REGION_UNMAPPED;
   endfunction

endpackage

// File: rtl/as512_mem_bridge_ram.sv
// Single-port synchronous word RAM: one-cycle registered read, write-first on write.
module as512_mem_bridge_ram #(
   parameter int RAM_AW = 12
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [RAM_AW-1:0] addr_i,
   input  logic [15:0]       wdata_i,
   output logic [15:0]       rdata_o
);

   logic [15:0] mem_q [2**RAM_AW];

   // Registered access port; a write also presents the new data on rdata_o.
   // NOTE: the array has no reset -- RAM contents are undefined after power-up and
   // resetting them would force the storage into flops instead of a RAM macro.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_o       <= wdata_i;
         end else begin
            rdata_o <= mem_q[addr_i];
         end
      end
   end

endmodule

// File: rtl/as512_mem_bridge.sv
// Bus bridge below the as512 core: demultiplexes LEN2/LEN1/OPREQ, serves a word RAM
// and a control window (counters, lockable write-protect limit, fault capture).
module as512_mem_bridge
   import as512_bus_pkg::*;
#(
   parameter int RAM_AW = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bus_din,
   output logic [15:0] bus_dout,
   input  logic        len2,
   input  logic        len1,
   input  logic        rw,
   input  logic        opreq,
   output logic        fault,
   output logic        wp_locked
);

   logic [15:0] addr_hi_q, addr_hi_d;
   logic [15:0] addr_lo_q, addr_lo_d;
   region_e     src_q, src_d;            // region of the last launched read
   logic        fresh_q, fresh_d;        // RAM read data arrives this cycle
   logic [15:0] hold_q, hold_d;          // RAM read data kept until the next launch
   logic [15:0] snap_q, snap_d;          // control register snapshot
   logic [31:0] rd_count_q, rd_count_d;
   logic [31:0] wr_count_q, wr_count_d;
   logic [15:0] rd_shadow_q, rd_shadow_d;
   logic [15:0] wr_shadow_q, wr_shadow_d;
   logic [15:0] wp_limit_q, wp_limit_d;
   logic        lock_q, lock_d;
   logic [31:0] fault_addr_q, fault_addr_d;
   logic        fault_q, fault_d;

   logic        launch, do_read, do_write, ram_prot, ram_en, ram_we, fault_now;
   region_e     cur_region, spec_region;
   logic [RAM_AW-1:0] ram_addr;
   logic [15:0] ram_rdata, ctrl_rdata;

   // len2 has priority, so a simultaneous len1 neither latches nor launches a read.
   assign launch      = len1 & ~len2;
   assign do_read     = opreq & ~rw;
   assign do_write    = opreq & rw;
   assign cur_region  = decode(addr_hi_q, addr_lo_q, RAM_AW);
   assign spec_region = decode(addr_hi_q, bus_din, RAM_AW);
   assign ram_prot    = addr_lo_q < wp_limit_q;
   assign ram_we      = do_write & (cur_region == REGION_RAM) & ~ram_prot & ~rst;
   assign ram_en      = launch | ram_we;
   assign ram_addr    = ram_we ? addr_lo_q[RAM_AW-1:0] : bus_din[RAM_AW-1:0];
   assign fault_now   = (opreq & (cur_region == REGION_UNMAPPED)) |
                        (do_write & (cur_region == REGION_RAM) & ram_prot);

   as512_mem_bridge_ram #(.RAM_AW(RAM_AW)) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (bus_din),
      .rdata_o (ram_rdata)
   );

   // Control register selected by the address half currently on the bus.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      ctrl_rdata = 16'h0000;
      case (bus_din[2:0])
         CTRL_RD_LO:    ctrl_rdata = rd_count_q[15:0];
         CTRL_RD_HI:    ctrl_rdata = rd_shadow_q;
         CTRL_WR_LO:    ctrl_rdata = wr_count_q[15:0];
         CTRL_WR_HI:    ctrl_rdata = wr_shadow_q;
         CTRL_WP_LIMIT: ctrl_rdata = wp_limit_q;
         CTRL_LOCK:     ctrl_rdata = {15'h0000, lock_q};
         CTRL_FA_LO:    ctrl_rdata = fault_addr_q[15:0];
         CTRL_FA_HI:    ctrl_rdata = fault_addr_q[31:16];
      endcase
   end

   // Next-state: address latch, read launch, counters, control writes, fault capture.
   always_comb begin
      addr_hi_d    = addr_hi_q;
      addr_lo_d    = addr_lo_q;
      src_d        = src_q;
      snap_d       = snap_q;
      fresh_d      = launch;
      hold_d       = fresh_q ? ram_rdata : hold_q;
      rd_count_d   = rd_count_q;
      wr_count_d   = wr_count_q;
      rd_shadow_d  = rd_shadow_q;
      wr_shadow_d  = wr_shadow_q;
      wp_limit_d   = wp_limit_q;
      lock_d       = lock_q;
      fault_addr_d = fault_addr_q;
      fault_d      = fault_now;

      if (len2) begin
         addr_hi_d = bus_din;
      end else if (len1) begin
         addr_lo_d = bus_din;
         src_d     = spec_region;
         snap_d    = ctrl_rdata;
      end

      if (do_read) begin
         rd_count_d = rd_count_q + 32'd1;
         // Shadows take the high half at the same count the low-half snapshot saw.
         if (cur_region == REGION_CTRL && addr_lo_q[2:0] == CTRL_RD_LO)
            rd_shadow_d = rd_count_q[31:16];
         if (cur_region == REGION_CTRL && addr_lo_q[2:0] == CTRL_WR_LO)
            wr_shadow_d = wr_count_q[31:16];
      end

      if (do_write) begin
         wr_count_d = wr_count_q + 32'd1;
         if (cur_region == REGION_CTRL) begin
            if (addr_lo_q[2:0] == CTRL_WP_LIMIT && !lock_q) wp_limit_d = bus_din;
            if (addr_lo_q[2:0] == CTRL_LOCK && bus_din == LOCK_KEY) lock_d = 1'b1;
         end
      end

      if (fault_now) fault_addr_d = {addr_hi_q, addr_lo_q};
   end

   // State register with synchronous reset; a reset cycle discards any pending update.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_hi_q    <= ADDR_HI_RESET;
         addr_lo_q    <= 16'h0000;
         src_q        <= REGION_CTRL;
         snap_q       <= 16'h0000;
         fresh_q      <= 1'b0;
         hold_q       <= 16'h0000;
         rd_count_q   <= 32'h0;
         wr_count_q   <= 32'h0;
         rd_shadow_q  <= 16'h0000;
         wr_shadow_q  <= 16'h0000;
         wp_limit_q   <= 16'h0000;
         lock_q       <= 1'b0;
         fault_addr_q <= 32'h0;
         fault_q      <= 1'b0;
      end else begin
         addr_hi_q    <= addr_hi_d;
         addr_lo_q    <= addr_lo_d;
         src_q        <= src_d;
         snap_q       <= snap_d;
         fresh_q      <= fresh_d;
         hold_q       <= hold_d;
         rd_count_q   <= rd_count_d;
         wr_count_q   <= wr_count_d;
         rd_shadow_q  <= rd_shadow_d;
         wr_shadow_q  <= wr_shadow_d;
         wp_limit_q   <= wp_limit_d;
         lock_q       <= lock_d;
         fault_addr_q <= fault_addr_d;
         fault_q      <= fault_d;
      end
   end

   // Read data for the core: fresh RAM data, held RAM data, snapshot or unmapped fill.
   always_comb begin
      bus_dout = UNMAPPED_DATA;
      case (src_q)
         REGION_RAM:  bus_dout = fresh_q ? ram_rdata : hold_q;
         REGION_CTRL: bus_dout = snap_q;
         default:     bus_dout = UNMAPPED_DATA;
      endcase
   end

   assign fault     = fault_q;
   assign wp_locked = lock_q;

endmodule

// File: tb/tb_as512_mem_bridge.sv
// Self-checking bench for as512_mem_bridge: directed scenarios plus randomized
// core-style transactions against a transaction-level model of the bridge.
module tb_as512_mem_bridge;
   import as512_bus_pkg::*;

   localparam int RAM_AW    = 12;
   localparam int RAM_WORDS = 1 << RAM_AW;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] bus_din;
   logic [15:0] bus_dout;
   logic        len2, len1, rw, opreq;
   logic        fault, wp_locked;

   always #5 clk = ~clk;

   as512_mem_bridge #(.RAM_AW(RAM_AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_din   (bus_din),
      .bus_dout  (bus_dout),
      .len2      (len2),
      .len1      (len1),
      .rw        (rw),
      .opreq     (opreq),
      .fault     (fault),
      .wp_locked (wp_locked)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_mem   [RAM_WORDS];
   bit          m_known [RAM_WORDS];
   logic [15:0] m_hi, m_lo, m_wp, m_rd_sh, m_wr_sh, m_dout;
   logic [31:0] m_rd, m_wr, m_fa;
   bit          m_lock, m_fault, m_dout_known, m_init;

   // Expectations for the cycle currently on the bus.
   logic [15:0] exp_dout;
   bit          exp_dout_known, exp_fault, exp_lock, chk_en;
   logic [15:0] tb_hi;

   // 0 = RAM, 1 = control window, 2 = unmapped, from the flat 32-bit word address.
   function automatic int region_of(input logic [31:0] a);
      if (a < 32'(RAM_WORDS)) return 0;
      if (a >= 32'hFFFF_0000 && a < 32'hFFFF_0008) return 1;
      return 2;
   endfunction

   task automatic model_reset();
      m_hi = 16'hFFFF; m_lo = 16'h0000; m_wp = 16'h0000;
      m_rd_sh = 16'h0000; m_wr_sh = 16'h0000; m_dout = 16'h0000;
      m_rd = 32'h0; m_wr = 32'h0; m_fa = 32'h0;
      m_lock = 1'b0; m_fault = 1'b0; m_dout_known = 1'b1; m_init = 1'b1;
   endtask

   task automatic spec_read(input logic [31:0] a);
      logic [RAM_AW-1:0] w;
      w = a[RAM_AW-1:0];
      m_dout_known = 1'b1;
      case (region_of(a))
         0: begin m_dout = m_mem[w]; m_dout_known = m_known[w]; end
         1: case (a[2:0])
               3'd0: m_dout = m_rd[15:0];
               3'd1: m_dout = m_rd_sh;
               3'd2: m_dout = m_wr[15:0];
               3'd3: m_dout = m_wr_sh;
               3'd4: m_dout = m_wp;
               3'd5: m_dout = {15'h0, m_lock};
               3'd6: m_dout = m_fa[15:0];
               default: m_dout = m_fa[31:16];
            endcase
         default: m_dout = 16'hFFFF;
      endcase
   endtask

   // One bus cycle: publish expectations, drive inputs, advance the model past the edge.
   task automatic cycle(input bit l2, input bit l1, input bit w, input bit op,
                        input logic [15:0] d, input bit r);
      logic [31:0] a;
      int          kind;
      bit          f;
      @(posedge clk);
      #1;
      exp_dout = m_dout; exp_dout_known = m_dout_known;
      exp_fault = m_fault; exp_lock = m_lock; chk_en = m_init;
      rst = r; len2 = l2; len1 = l1; rw = w; opreq = op; bus_din = d;
      if (r) begin
         model_reset();
      end else begin
         f = 1'b0;
         a = {m_hi, m_lo};
         kind = region_of(a);
         if (l1 && !l2) spec_read({m_hi, d});
         if (op && !w) begin
            if (kind == 1 && m_lo[2:0] == 3'd0) m_rd_sh = m_rd[31:16];
            if (kind == 1 && m_lo[2:0] == 3'd2) m_wr_sh = m_wr[31:16];
            m_rd = m_rd + 1;
            if (kind == 2) f = 1'b1;
         end
         if (op && w) begin
            m_wr = m_wr + 1;
            if (kind == 2) f = 1'b1;
            else if (kind == 0) begin
               if (m_lo < m_wp) f = 1'b1;
               else begin
                  m_mem[a[RAM_AW-1:0]] = d;
                  m_known[a[RAM_AW-1:0]] = 1'b1;
               end
            end else begin
               if (m_lo[2:0] == 3'd4 && !m_lock) m_wp = d;
               if (m_lo[2:0] == 3'd5 && d == LOCK_KEY) m_lock = 1'b1;
            end
         end
         if (f) m_fa = a;
         m_fault = f;
         if (l2) m_hi = d;
         else if (l1) m_lo = d;
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
   endtask

   // Core-style transaction: optional len2, len1, then the opreq data phase.
   task automatic xfer(input logic [15:0] hi, input logic [15:0] lo, input bit w,
                       input logic [15:0] d, input bit force_l2);
      if (hi != tb_hi || force_l2) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0, hi, 1'b0);
         tb_hi = hi;
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, lo, 1'b0);
      cycle(1'b0, 1'b0, w, 1'b1, d, 1'b0);
   endtask

   // Pin both the DUT and the model to a hand-computed read value in the opreq cycle.
   task automatic expect_dout(input string name, input logic [15:0] lit);
      check(name, 32'(bus_dout), 32'(lit));
      check({name, "_model"}, 32'(exp_dout), 32'(lit));
   endtask

   // Every-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         if (exp_dout_known) check("bus_dout", 32'(bus_dout), 32'(exp_dout));
         check("fault", 32'(fault), 32'(exp_fault));
         check("wp_locked", 32'(wp_locked), 32'(exp_lock));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] hi, lo, d;
      int          sel;
      rst = 1'b1; len2 = 1'b0; len1 = 1'b0; rw = 1'b0; opreq = 1'b0; bus_din = 16'h0;
      tb_hi = 16'hFFFF; chk_en = 1'b0; m_init = 1'b0;
      for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;

      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      idle();
      check("rst_dout", 32'(bus_dout), 32'h0);
      check("rst_fault", 32'(fault), 32'h0);
      check("rst_lock", 32'(wp_locked), 32'h0);

      // Basic write / read back and counters.
      xfer(16'h0000, 16'h0010, 1'b1, 16'h1234, 1'b0);
      xfer(16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b0);
      expect_dout("ram_rd_0x10", 16'h1234);
      xfer(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
      expect_dout("rd_count_1", 16'h0001);
      xfer(16'hFFFF, 16'h0002, 1'b0, 16'h0000, 1'b0);
      expect_dout("wr_count_1", 16'h0001);

      // Unmapped read: fill data, single-cycle fault, captured address.
      xfer(16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0);
      expect_dout("unmapped_rd", 16'hFFFF);
      idle();
      check("fault_pulse", 32'(fault), 32'h1);
      idle();
      check("fault_one_clk", 32'(fault), 32'h0);
      xfer(16'hFFFF, 16'h0006, 1'b0, 16'h0000, 1'b0);
      expect_dout("fault_addr_lo", 16'h0000);
      xfer(16'hFFFF, 16'h0007, 1'b0, 16'h0000, 1'b0);
      expect_dout("fault_addr_hi", 16'h0001);

      // Write protect and lock.
      xfer(16'hFFFF, 16'h0004, 1'b1, 16'h0020, 1'b0);
      xfer(16'hFFFF, 16'h0005, 1'b1, LOCK_KEY, 1'b0);
      idle();
      check("locked", 32'(wp_locked), 32'h1);
      xfer(16'h0000, 16'h0010, 1'b1, 16'hBEEF, 1'b0);
      idle();
      check("prot_fault", 32'(fault), 32'h1);
      xfer(16'hFFFF, 16'h0004, 1'b1, 16'h0000, 1'b0);
      xfer(16'hFFFF, 16'h0004, 1'b0, 16'h0000, 1'b0);
      expect_dout("wp_limit_kept", 16'h0020);
      xfer(16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b0);
      expect_dout("prot_dropped", 16'h1234);

      // Read counter wrap and shadow coherence.
      idle();
      force dut.rd_count_q = 32'hFFFF_FFFF;
      idle();
      release dut.rd_count_q;
      m_rd = 32'hFFFF_FFFF;
      idle();
      xfer(16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b0);
      xfer(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
      expect_dout("wrap_lo", 16'h0000);
      xfer(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
      expect_dout("wrap_shadow", 16'h0000);
      xfer(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
      expect_dout("after_wrap_lo", 16'h0002);

      // len2 and len1 together: only the high half loads.
      xfer(16'hFFFF, 16'h0005, 1'b0, 16'h0000, 1'b0);
      expect_dout("lock_reg", 16'h0001);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      tb_hi = 16'h0000;
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b0);
      idle();
      check("dual_len_fault", 32'(fault), 32'h1);
      xfer(16'hFFFF, 16'h0006, 1'b0, 16'h0000, 1'b0);
      expect_dout("dual_len_lo", 16'h0005);
      xfer(16'hFFFF, 16'h0007, 1'b0, 16'h0000, 1'b0);
      expect_dout("dual_len_hi", 16'h0000);

      // Reset during a write data phase.
      xfer(16'h0000, 16'h0030, 1'b1, 16'h1111, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b1);
      tb_hi = 16'hFFFF;
      idle();
      check("rst_mid_dout", 32'(bus_dout), 32'h0);
      check("rst_mid_lock", 32'(wp_locked), 32'h0);
      xfer(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
      expect_dout("rst_mid_rd_count", 16'h0000);
      xfer(16'hFFFF, 16'h0002, 1'b0, 16'h0000, 1'b0);
      expect_dout("rst_mid_wr_count", 16'h0000);
      xfer(16'h0000, 16'h0030, 1'b0, 16'h0000, 1'b0);
      expect_dout("rst_mid_ram", 16'h1111);

      // Randomized core-style traffic.
      for (int n = 0; n < 1500; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 5) begin
            hi = 16'h0000;
            case ($urandom_range(0, 3))
               0:       lo = 16'($urandom_range(0, RAM_WORDS - 1));
               1:       lo = 16'($urandom_range(RAM_WORDS, 16'hFFFF));
               default: lo = 16'($urandom_range(0, 63));
            endcase
         end else if (sel < 8) begin
            hi = 16'hFFFF;
            lo = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(8, 15))
                                             : 16'($urandom_range(0, 7));
         end else begin
            hi = 16'($urandom);
            lo = 16'($urandom);
         end
         d = 16'($urandom);
         if (hi == 16'hFFFF && lo == 16'h0004) d = 16'($urandom_range(0, 48));
         if (hi == 16'hFFFF && lo == 16'h0005 && $urandom_range(0, 7) == 0) d = LOCK_KEY;
         xfer(hi, lo, 1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) == 0));
         for (int k = $urandom_range(0, 2); k > 0; k--) idle();
      end
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
